// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - round-robin front end for the bit-manipulation ALU datapath
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [2:0]            req0_opcode,
   input  logic [DATA_WIDTH-1:0] req0_operand,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [2:0]            req1_opcode,
   input  logic [DATA_WIDTH-1:0] req1_operand,
   output logic                  req1_ready,
   output logic                  dp_valid,
   output logic [2:0]            dp_opcode,
   output logic [DATA_WIDTH-1:0] dp_operand,
   input  logic [DATA_WIDTH-1:0] dp_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t                state, state_n;
   logic [3:0]            counter, counter_n;
   logic                  last_grant, last_grant_n;
   logic [2:0]            dp_opcode_n;
   logic [DATA_WIDTH-1:0] dp_operand_n;
   logic [DATA_WIDTH-1:0] rsp_data_n;
   logic                  rsp_id_n, rsp_err_n;
   logic                  any_req, grant, take;
   logic [2:0]            grant_opcode;
   logic [DATA_WIDTH-1:0] grant_operand;

   // Ties go to the requester that did not win last; a lone requester always wins.
   always_comb begin
      any_req       = req0_valid | req1_valid;
      grant         = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
      take          = (state == IDLE) && !rst && any_req;
      req0_ready    = take && !grant;
      req1_ready    = take && grant;
      grant_opcode  = grant ? req1_opcode : req0_opcode;
      grant_operand = grant ? req1_operand : req0_operand;
   end

   always_comb begin
      state_n      = state;
      counter_n    = counter;
      last_grant_n = last_grant;
      dp_opcode_n  = dp_opcode;
      dp_operand_n = dp_operand;
      rsp_data_n   = rsp_data;
      rsp_id_n     = rsp_id;
      rsp_err_n    = rsp_err;
      case (state)
         IDLE: begin
            if (take) begin
               last_grant_n = grant;
               rsp_id_n     = grant;
               // Opcodes 4..7 bypass the datapath entirely.
               if (grant_opcode[2]) begin
                  rsp_data_n = '0;
                  rsp_err_n  = 1'b1;
                  state_n    = RESP;
               end else begin
                  dp_opcode_n  = grant_opcode;
                  dp_operand_n = grant_operand;
                  counter_n    = LAT;
                  state_n      = WAIT;
               end
            end
         end
         WAIT: begin
            if (counter == 4'd0) begin
               rsp_data_n = dp_result;
               rsp_err_n  = 1'b0;
               state_n    = RESP;
            end else begin
               counter_n = counter - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= 4'd0;
         last_grant <= 1'b1;
         dp_opcode  <= 3'd0;
         dp_operand <= '0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_n;
         counter    <= counter_n;
         last_grant <= last_grant_n;
         dp_opcode  <= dp_opcode_n;
         dp_operand <= dp_operand_n;
         rsp_data   <= rsp_data_n;
         rsp_id     <= rsp_id_n;
         rsp_err    <= rsp_err_n;
      end
   end

   assign dp_valid  = (state == WAIT);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
   localparam int W   = 64;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         rst, rsp_ready;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [2:0]   req0_opcode, req1_opcode, dp_opcode;
   logic [W-1:0] req0_operand, req1_operand, dp_operand, dp_result, rsp_data;
   logic         dp_valid, rsp_valid, rsp_id, rsp_err, busy;

   logic         l1_rst, l1_rsp_ready, l1_req0_valid, l1_req0_ready, l1_req1_ready;
   logic [2:0]   l1_req0_opcode, l1_dp_opcode;
   logic [W-1:0] l1_req0_operand, l1_dp_operand, l1_dp_result, l1_rsp_data;
   logic         l1_dp_valid, l1_rsp_valid, l1_rsp_id, l1_rsp_err, l1_busy;
   logic         l1_req1_valid = 1'b0;
   logic [2:0]   l1_req1_opcode = 3'd0;
   logic [W-1:0] l1_req1_operand = '0;

   // Stand-in ALU: parity, popcount, rotate by one; the result is only correct on the last dp_valid cycle.
   function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a);
      case (op)
         3'd0:    return {{(W-1){1'b0}}, ^a};
         3'd1:    return W'($countones(a));
         3'd2:    return {a[0], a[W-1:1]};
         3'd3:    return {a[W-2:0], a[W-1]};
         default: return '0;
      endcase
   endfunction

   logic [4:0] vcnt = 5'd0, l1_vcnt = 5'd0;
   always @(posedge clk) vcnt <= dp_valid ? vcnt + 5'd1 : 5'd0;
   always @(posedge clk) l1_vcnt <= l1_dp_valid ? l1_vcnt + 5'd1 : 5'd0;
   assign dp_result    = (vcnt == 5'd2) ? alu_f(dp_opcode, dp_operand) : ~alu_f(dp_opcode, dp_operand);
   assign l1_dp_result = (l1_vcnt == 5'd1) ? alu_f(l1_dp_opcode, l1_dp_operand) : ~alu_f(l1_dp_opcode, l1_dp_operand);

   alu_op_sequencer #(.DATA_WIDTH(W), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_operand(req0_operand), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_operand(req1_operand), .req1_ready(req1_ready),
      .dp_valid(dp_valid), .dp_opcode(dp_opcode), .dp_operand(dp_operand), .dp_result(dp_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy));

   alu_op_sequencer #(.DATA_WIDTH(W), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(l1_rst),
      .req0_valid(l1_req0_valid), .req0_opcode(l1_req0_opcode), .req0_operand(l1_req0_operand), .req0_ready(l1_req0_ready),
      .req1_valid(l1_req1_valid), .req1_opcode(l1_req1_opcode), .req1_operand(l1_req1_operand), .req1_ready(l1_req1_ready),
      .dp_valid(l1_dp_valid), .dp_opcode(l1_dp_opcode), .dp_operand(l1_dp_operand), .dp_result(l1_dp_result),
      .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id), .rsp_data(l1_rsp_data),
      .rsp_err(l1_rsp_err), .busy(l1_busy));

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction-level model: cycles since grant decide the phase; response is the ALU function of the granted request.
   int           m_t = -1;
   logic         m_last = 1'b1, m_id, m_err;
   logic [2:0]   m_op;
   logic [W-1:0] m_operand, m_exp;
   int           grant_q[$];
   int           rid_q[$];
   logic [W-1:0] rdata_q[$];

   initial begin
      logic idle, resp, in_wait, g_any, g_id;
      logic [2:0] op;
      logic [W-1:0] a;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_t    = -1;
            m_last = 1'b1;
         end else begin
            idle    = (m_t < 0);
            resp    = !idle && (m_err || m_t >= LAT + 2);
            in_wait = !idle && !resp;
            g_any   = idle && (req0_valid || req1_valid);
            g_id    = (req0_valid && req1_valid) ? !m_last : !req0_valid;
            chk("busy", busy, !idle);
            chk("dp_valid", dp_valid, in_wait);
            chk("rsp_valid", rsp_valid, resp);
            chk("req0_ready", req0_ready, g_any && !g_id);
            chk("req1_ready", req1_ready, g_any && g_id);
            if (in_wait) begin
               chk("dp_opcode", dp_opcode, m_op);
               chk("dp_operand", dp_operand, m_operand);
            end
            if (resp) begin
               chk("rsp_id", rsp_id, m_id);
               chk("rsp_err", rsp_err, m_err);
               chk("rsp_data", rsp_data, m_err ? '0 : m_exp);
            end
            if (req0_valid && req0_ready) grant_q.push_back(0);
            if (req1_valid && req1_ready) grant_q.push_back(1);
            if (rsp_valid && rsp_ready) begin
               rid_q.push_back(int'(rsp_id));
               rdata_q.push_back(rsp_data);
            end
            if (g_any) begin
               op        = g_id ? req1_opcode : req0_opcode;
               a         = g_id ? req1_operand : req0_operand;
               m_t       = 1;
               m_id      = g_id;
               m_last    = g_id;
               m_op      = op;
               m_operand = a;
               m_err     = (op > 3'd3);
               m_exp     = alu_f(op, a);
            end else if (resp && rsp_ready) begin
               m_t = -1;
            end else if (!idle) begin
               m_t++;
            end
         end
      end
   end

   task automatic drive(input int id, input logic v, input logic [2:0] op, input logic [W-1:0] a);
      if (id == 0) begin
         req0_valid = v; req0_opcode = op; req0_operand = a;
      end else begin
         req1_valid = v; req1_opcode = op; req1_operand = a;
      end
   endtask

   task automatic do_req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         output int rdy, output int dpv, output int lat,
                         output logic [W-1:0] data, output logic err, output logic rid);
      int gk;
      logic r;
      gk = -1; rdy = 0; dpv = 0; lat = -1; data = '0; err = 1'b0; rid = 1'b0;
      drive(id, 1'b1, op, a);
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         r = (id == 0) ? req0_ready : req1_ready;
         if (r) rdy++;
         if (dp_valid) dpv++;
         if (gk >= 0 && rsp_valid) begin
            lat = k - gk; data = rsp_data; err = rsp_err; rid = rsp_id;
         end
         if (r) gk = k;
         @(posedge clk); #1;
         if (gk >= 0) drive(id, 1'b0, op, a);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_timeout", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      int rdy, dpv, lat, gb, rb, nr;
      logic [W-1:0] data;
      logic err, rid;
      rst = 1'b1; rsp_ready = 1'b1;
      drive(0, 1'b0, 3'd0, '0);
      drive(1, 1'b0, 3'd0, '0);
      l1_rst = 1'b1; l1_rsp_ready = 1'b1;
      l1_req0_valid = 1'b0; l1_req0_opcode = 3'd0; l1_req0_operand = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset busy", busy, 1'b0);
      chk("reset dp_valid", dp_valid, 1'b0);
      chk("reset rsp_valid", rsp_valid, 1'b0);
      chk("reset dp_opcode", dp_opcode, 3'd0);
      chk("reset dp_operand", dp_operand, '0);
      chk("reset rsp_data", rsp_data, '0);
      chk("reset rsp_id", rsp_id, 1'b0);
      chk("reset rsp_err", rsp_err, 1'b0);
      @(posedge clk); #1;

      do_req(0, 3'd1, 64'hFF, rdy, dpv, lat, data, err, rid);
      chk("pop ready cycles", rdy, 1);
      chk("pop dp_valid cycles", dpv, 3);
      chk("pop latency", lat, 4);
      chk("pop data", data, 64'd8);
      chk("pop err", err, 1'b0);
      chk("pop id", rid, 1'b0);
      wait_idle();

      // Fairness from a fresh reset: both requesters held valid throughout.
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      gb = grant_q.size(); rb = rid_q.size();
      drive(0, 1'b1, 3'd0, 64'h7);
      drive(1, 1'b1, 3'd3, 64'h8000_0000_0000_0001);
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (grant_q.size() >= gb + 4) break;
      end
      drive(0, 1'b0, 3'd0, '0);
      drive(1, 1'b0, 3'd0, '0);
      wait_idle();
      repeat (2) @(posedge clk); #1;
      chk("fair grant count", grant_q.size() - gb, 4);
      chk("fair rsp count", rid_q.size() - rb, 4);
      if (grant_q.size() >= gb + 4 && rid_q.size() >= rb + 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair grant %0d", i), grant_q[gb + i], i % 2);
            chk($sformatf("fair rsp_id %0d", i), rid_q[rb + i], i % 2);
         end
         chk("fair parity data", rdata_q[rb], 64'd1);
         chk("fair rotl data", rdata_q[rb + 1], 64'h3);
      end

      do_req(1, 3'd5, 64'h1234, rdy, dpv, lat, data, err, rid);
      chk("ill ready cycles", rdy, 1);
      chk("ill dp_valid cycles", dpv, 0);
      chk("ill latency", lat, 1);
      chk("ill data", data, '0);
      chk("ill err", err, 1'b1);
      chk("ill id", rid, 1'b1);
      wait_idle();

      // Back-pressure in RESP while requester 1 waits.
      rsp_ready = 1'b0;
      drive(0, 1'b1, 3'd2, 64'h2);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req0_ready) break;
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd0, '0);
      drive(1, 1'b1, 3'd1, 64'h3);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("bp rsp_valid reached", rsp_valid, 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp rsp_data held", rsp_data, 64'h1);
         chk("bp req1_ready low", req1_ready, 1'b0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp handshake no grant", req1_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp next grant", req1_ready, 1'b1);
      @(posedge clk); #1;
      drive(1, 1'b0, 3'd0, '0);
      wait_idle();
      chk("bp req1 popcount", rdata_q[$], 64'd2);

      // Reset while WAIT has counter==1.
      drive(0, 1'b1, 3'd1, 64'hF);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req0_ready) break;
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd0, '0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst busy", busy, 1'b0);
      chk("rst dp_valid", dp_valid, 1'b0);
      chk("rst rsp_valid", rsp_valid, 1'b0);
      nr = rid_q.size();
      repeat (8) @(posedge clk); #1;
      chk("rst no response", rid_q.size(), nr);
      gb = grant_q.size();
      drive(0, 1'b1, 3'd0, 64'h1);
      drive(1, 1'b1, 3'd0, 64'h3);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (grant_q.size() > gb) break;
      end
      drive(0, 1'b0, 3'd0, '0);
      drive(1, 1'b0, 3'd0, '0);
      chk("rst first grant", (grant_q.size() > gb) ? grant_q[gb] : -1, 0);
      wait_idle();

      // LATENCY=1 instance: ROTR.
      l1_rst = 1'b0;
      l1_req0_valid = 1'b1; l1_req0_opcode = 3'd2; l1_req0_operand = 64'h1;
      begin
         int gk, l1_dpv, l1_lat;
         logic [W-1:0] l1_data;
         gk = -1; l1_dpv = 0; l1_lat = -1; l1_data = '0;
         for (int k = 0; k < 20 && l1_lat < 0; k++) begin
            @(negedge clk);
            if (l1_dp_valid) l1_dpv++;
            if (gk >= 0 && l1_rsp_valid) begin
               l1_lat = k - gk; l1_data = l1_rsp_data;
            end
            if (l1_req0_ready) gk = k;
            @(posedge clk); #1;
            if (gk >= 0) l1_req0_valid = 1'b0;
         end
         chk("l1 dp_valid cycles", l1_dpv, 2);
         chk("l1 latency", l1_lat, 3);
         chk("l1 rotr data", l1_data, 64'h8000_0000_0000_0000);
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Two-requester front end for the bit-manipulation ALU: parity, popcount, rotate-right and rotate-left units feeding the registered result mux.
- Arbitrates requests round-robin and drives opcode/operand to the datapath with stable hold.
- Waits out the fixed datapath latency, captures `alu_out` and returns it to the winning requester over a valid/ready response channel.
- One operation in flight at a time. Illegal opcodes are rejected without touching the datapath.

Parameters:
- DATA_WIDTH, 1024, operand/result width; matches the ALU datapath.
- LATENCY, 2, cycles from first dp_valid cycle to the cycle dp_result is valid; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_opcode  input  3  0=PARITY 1=POPCOUNT 2=ROTR 3=ROTL, 4..7 illegal
- req0_operand  input  DATA_WIDTH  operand
- req0_ready  output  1  request 0 accepted this cycle
- req1_valid / req1_opcode / req1_operand / req1_ready  same as requester 0, for requester 1
- dp_valid  output  1  high while datapath inputs are driven (WAIT state)
- dp_opcode  output  3  registered opcode to datapath
- dp_operand  output  DATA_WIDTH  registered operand to datapath
- dp_result  input  DATA_WIDTH  datapath result (alu_out)
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that owns the response
- rsp_data  output  DATA_WIDTH  result; 0 on error
- rsp_err  output  1  illegal opcode
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, dp_opcode=0, dp_operand=0, last_grant=1 (so requester 0 wins first), counter=0.
- States: IDLE, WAIT, RESP.
- IDLE arbitration:
  - Grant = the only valid requester.
  - If both are valid, grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N, combinational. The other ready stays 0.
  - Handshake completes in the same cycle. At that edge: last_grant<=N, rsp_id<=N.
- Legal opcode (0..3) at grant edge:
  - dp_opcode/dp_operand load the request fields; counter<=LATENCY; state->WAIT.
- Illegal opcode (4..7) at grant edge:
  - state->RESP directly; rsp_data<=0; rsp_err<=1.
  - dp_valid never asserts; dp_opcode/dp_operand unchanged.
- WAIT:
  - dp_valid=1; dp_opcode/dp_operand held constant.
  - Counter decrements each cycle.
  - In the cycle counter==0: rsp_data<=dp_result, rsp_err<=0, state->RESP.
  - Timing: grant edge at end of cycle C; dp_valid high C+1..C+1+LATENCY; capture at end of C+1+LATENCY; rsp_valid from C+2+LATENCY. With LATENCY=2, grant-to-rsp_valid is 4 cycles.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err held stable until rsp_valid && rsp_ready.
  - At the handshake edge: state->IDLE, rsp_valid->0.
  - No new grant occurs in the handshake cycle; earliest next grant is the following cycle.
  - Back-pressure of any length holds RESP indefinitely.
- Requesters not granted see ready=0 and must hold valid and fields; no request is dropped.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- rst asserted in any state: next cycle all state and outputs return to reset values. The in-flight op and any pending response are discarded; no response is emitted for it.
- No X ever driven on rsp_data.

Test Plan:
- Reset, then req0 POPCOUNT operand=0xFF, dp_result model returns 8 at LATENCY=2 → req0_ready one cycle, dp_valid 3 cycles with dp_opcode=1, rsp_valid 4 cycles after grant, rsp_data=8, rsp_id=0, rsp_err=0.
- Both requesters valid continuously (req0 PARITY, req1 ROTL), rsp_ready=1 → grant order 0,1,0,1; rsp_id sequence matches; each requester's dp_operand matches its own request.
- req1 opcode=5 → req1_ready, no dp_valid, rsp_valid next cycle with rsp_err=1, rsp_data=0, rsp_id=1.
- rsp_ready held 0 for 10 cycles in RESP → rsp_valid/rsp_data stable, req0_ready and req1_ready stay 0; release → IDLE, next grant one cycle later.
- rst pulsed for one cycle during WAIT (counter=1) → next cycle busy=0, dp_valid=0, rsp_valid=0; no response appears afterward; req0 wins the next arbitration.
- LATENCY=1 build: ROTR request → dp_valid 2 cycles, rsp_valid 3 cycles after grant with captured dp_result.
